apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester for the APB memory slave; the only driver of its psel/penable/pWRITE/pADDr/pWDATA/pSTRB.
- Accepts single transfer commands on a valid/ready request port and sequences them through APB SETUP and ACCESS phases.
- Waits on pREADY, up to a bounded timeout, then returns read data or an error on a one-cycle response strobe.

Parameters:
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 32, APB data width.
- STRB_WIDTH, DATA_WIDTH/8, one write strobe per byte lane.
- TIMEOUT, 16, maximum ACCESS cycles with pREADY low before the transfer is aborted (minimum 1).

Ports:
- pclk  in  1  clock; all state changes on the rising edge.
- prst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted this cycle when req_valid is also high (combinational).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  STRB_WIDTH  byte-lane write enables.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_WIDTH  captured pRDATA for reads; 0 for writes and on error.
- rsp_err  out  1  transfer timed out; qualified by rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pWRITE  out  1  APB direction.
- pADDr  out  ADDR_WIDTH  APB address.
- pWDATA  out  DATA_WIDTH  APB write data.
- pSTRB  out  STRB_WIDTH  APB strobes.
- pREADY  in  1  slave ready.
- pRDATA  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset, applied asynchronously: every output, the state and the wait counter go to 0 and state goes to IDLE. A transfer in flight is dropped silently, with no rsp_valid.
- All APB outputs and rsp_* are registered.
- FSM has three states: IDLE, SETUP and ACCESS.
- IDLE:
  - psel=0, penable=0; pADDr, pWDATA, pSTRB and pWRITE hold their last values.
  - req_ready=1.
  - When req_valid=1, latch the command into the APB outputs and go to SETUP.
  - pSTRB takes req_strb for writes and is forced to 0 for reads.
- SETUP:
  - psel=1, penable=0, req_ready=0.
  - Go unconditionally to ACCESS; the wait counter clears to 0.
- ACCESS:
  - psel=1, penable=1, and the address, data, direction and strobes are stable.
  - If pREADY=1, the transfer completes:
    - Next cycle rsp_valid=1 and rsp_err=0.
    - rsp_rdata = pRDATA sampled on this edge for a read, 0 for a write.
  - If pREADY=0 and the wait counter equals TIMEOUT-1, the transfer aborts:
    - Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - psel and penable drop.
  - Otherwise the counter increments and the block stays in ACCESS.
- Completion or abort edge:
  - req_ready=1 on that cycle.
  - If req_valid=1, latch the new command and go directly to SETUP. psel stays 1 and penable drops to 0, which gives back-to-back transfers with no IDLE gap.
  - If req_valid=0, go to IDLE.
- req_ready=0 in every other cycle. Command inputs are ignored unless req_valid and req_ready are both high.
- rsp_valid is high for exactly one cycle per accepted command and is low otherwise. rsp_rdata and rsp_err hold their values until the next response.
- Minimum latency from acceptance edge to rsp_valid is 3 cycles: SETUP, then ACCESS with pREADY=1, then the response cycle.
- Wait counter width is clog2(TIMEOUT)+1, so it cannot overflow.
- If pREADY and the timeout condition occur in the same cycle, pREADY wins: normal completion, rsp_err=0.
- pREADY outside ACCESS is ignored.
- Illegal state encodings return to IDLE.

Test Plan:
- Single write:
  - Stimulus: req addr=0x10, wdata=0xDEADBEEF, strb=4'hF, write=1; slave answers pREADY one ACCESS cycle late.
  - Required: psel 0→1 and penable 1 cycle later, held until pREADY; rsp_valid pulse with rsp_err=0, rsp_rdata=0.
  - Required: a read of 0x10 then returns 0xDEADBEEF.
- Partial strobe:
  - Stimulus: write 0x11223344 with strb=4'b0101 over 0xFFFFFFFF at addr 0x20, then read 0x20.
  - Required: rsp_rdata=0xFF22FF44.
  - Required: pSTRB=0 observed during the read.
- Back-to-back:
  - Stimulus: req_valid held high with 3 commands (write 0x01, write 0x02, read 0x01).
  - Required: no IDLE cycle between transfers; penable low for exactly one cycle between them; exactly 3 rsp_valid pulses in order.
- Timeout:
  - Stimulus: pREADY tied 0, read at 0x30.
  - Required: ACCESS lasts exactly TIMEOUT=16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; psel returns to 0; the next command proceeds normally.
- Reset mid-transfer:
  - Stimulus: assert prst asynchronously, mid-cycle, during ACCESS.
  - Required: psel, penable and rsp_valid go to 0 immediately, with no response pulse.
  - Required: after release, req_ready=1 and a new read completes normally.
- Timeout/ready race:
  - Stimulus: pREADY rises on ACCESS cycle 16.
  - Required: normal completion with rsp_err=0.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bundle between a command/response requester, the APB bridge and an APB completer.
// The bridge drives the APB side through the master modport; the environment uses slave.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // Request handshake: a command transfers on a rising pclk edge where req_valid and
    // req_ready are both high; req_ready is combinational and req_valid must not wait on it.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pWRITE;
    logic [ADDR_WIDTH-1:0] pADDr;
    logic [DATA_WIDTH-1:0] pWDATA;
    logic [STRB_WIDTH-1:0] pSTRB;
    logic                  pREADY;
    logic [DATA_WIDTH-1:0] pRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  pREADY, pRDATA,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pWRITE, pADDr, pWDATA, pSTRB
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output pREADY, pRDATA,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pWRITE, pADDr, pWDATA, pSTRB
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS transfers,
// bounds the pREADY wait and returns data or a timeout error on a one-cycle strobe.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                pclk,
    input  logic                prst,
    apb_master_bridge_if.master bus,
    output logic [1:0]          dbgState
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [CNT_W-1:0]      waitCnt;
    logic [CNT_W-1:0]      waitCntNext;
    logic                  reqReady;
    logic                  accept;

    logic                  pselNext;
    logic                  penableNext;
    logic                  pWriteNext;
    logic [ADDR_WIDTH-1:0] pAddrNext;
    logic [DATA_WIDTH-1:0] pWdataNext;
    logic [STRB_WIDTH-1:0] pStrbNext;
    logic                  rspValidNext;
    logic                  rspErrNext;
    logic [DATA_WIDTH-1:0] rspRdataNext;

    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        pselNext     = bus.psel;
        penableNext  = bus.penable;
        pWriteNext   = bus.pWRITE;
        pAddrNext    = bus.pADDr;
        pWdataNext   = bus.pWDATA;
        pStrbNext    = bus.pSTRB;
        rspValidNext = 1'b0;
        rspErrNext   = bus.rsp_err;
        rspRdataNext = bus.rsp_rdata;
        reqReady     = 1'b0;
        accept       = 1'b0;

        case (state)
            IDLE: begin
                reqReady    = 1'b1;
                pselNext    = 1'b0;
                penableNext = 1'b0;
            end
            SETUP: begin
                stateNext   = ACCESS;
                waitCntNext = '0;
                pselNext    = 1'b1;
                penableNext = 1'b1;
            end
            ACCESS: begin
                // pREADY is checked first so a late ready on the last wait cycle still completes.
                if (bus.pREADY) begin
                    reqReady     = 1'b1;
                    stateNext    = IDLE;
                    pselNext     = 1'b0;
                    penableNext  = 1'b0;
                    rspValidNext = 1'b1;
                    rspErrNext   = 1'b0;
                    rspRdataNext = bus.pWRITE ? '0 : bus.pRDATA;
                end else if (waitCnt == LAST_WAIT) begin
                    reqReady     = 1'b1;
                    stateNext    = IDLE;
                    pselNext     = 1'b0;
                    penableNext  = 1'b0;
                    rspValidNext = 1'b1;
                    rspErrNext   = 1'b1;
                    rspRdataNext = '0;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext   = IDLE;
                pselNext    = 1'b0;
                penableNext = 1'b0;
            end
        endcase

        // A command taken on a completion edge goes straight to SETUP, keeping psel high.
        accept = reqReady & bus.req_valid;
        if (accept) begin
            stateNext   = SETUP;
            pselNext    = 1'b1;
            penableNext = 1'b0;
            pWriteNext  = bus.req_write;
            pAddrNext   = bus.req_addr;
            pWdataNext  = bus.req_wdata;
            pStrbNext   = bus.req_write ? bus.req_strb : '0;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state         <= IDLE;
            waitCnt       <= '0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pWRITE    <= 1'b0;
            bus.pADDr     <= '0;
            bus.pWDATA    <= '0;
            bus.pSTRB     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            state         <= stateNext;
            waitCnt       <= waitCntNext;
            bus.psel      <= pselNext;
            bus.penable   <= penableNext;
            bus.pWRITE    <= pWriteNext;
            bus.pADDr     <= pAddrNext;
            bus.pWDATA    <= pWdataNext;
            bus.pSTRB     <= pStrbNext;
            bus.rsp_valid <= rspValidNext;
            bus.rsp_err   <= rspErrNext;
            bus.rsp_rdata <= rspRdataNext;
        end
    end

    // Held low while reset is asserted so every output reads 0 during reset.
    assign bus.req_ready = reqReady & ~prst;
    assign dbgState      = state;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized checks of apb_master_bridge against a byte-lane memory model
// and a queue of expected responses.
module tb_apb_master_bridge;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int TIMEOUT = 16;

    logic          pclk = 1'b0;
    logic          prst = 1'b0;
    logic [1:0]    dbgState;

    int            vectors     = 0;
    int            miscompares = 0;
    int            rspCount    = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] refMem [256];
    logic [DW-1:0] slvMem [256];
    int            slvWaits = 0;
    bit            slvStuck = 1'b0;
    int            accCnt;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .prst(prst), .bus(bus), .dbgState(dbgState)
    );

    // Clock / watchdog
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    // APB completer: pREADY after slvWaits ACCESS cycles, idles high outside ACCESS.
    always_comb begin
        if (slvStuck)                       bus.pREADY = 1'b0;
        else if (bus.psel && bus.penable)   bus.pREADY = (accCnt >= slvWaits);
        else                                bus.pREADY = 1'b1;
        bus.pRDATA = slvMem[bus.pADDr];
    end

    always @(posedge pclk or posedge prst) begin
        if (prst)                                         accCnt <= 0;
        else if (bus.psel && bus.penable && !bus.pREADY)  accCnt <= accCnt + 1;
        else                                              accCnt <= 0;
    end

    always @(posedge pclk) begin : slv_write
        logic [DW-1:0] m;
        if (!prst && bus.psel && bus.penable && bus.pREADY && bus.pWRITE) begin
            m = slvMem[bus.pADDr];
            for (int b = 0; b < SW; b++)
                if (bus.pSTRB[b]) m[8*b +: 8] = bus.pWDATA[8*b +: 8];
            slvMem[bus.pADDr] <= m;
        end
    end

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge pclk) begin
        if (!prst && bus.rsp_valid) begin
            rspCount++;
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", bus.rsp_valid, 0);
            end else begin
                chk("rsp_err_rdata", {bus.rsp_err, bus.rsp_rdata}, exp_q.pop_front());
            end
        end
    end

    // Reference: a completed write merges enabled bytes; a read returns the stored word.
    task automatic model(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input bit err, output logic [DW:0] r);
        if (err) begin
            r = {1'b1, {DW{1'b0}}};
        end else if (wr) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) refMem[a][8*b +: 8] = d[8*b +: 8];
            r = {1'b0, {DW{1'b0}}};
        end else begin
            r = {1'b0, refMem[a]};
        end
    endtask

    task automatic drive(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_strb  = s;
    endtask

    task automatic do_xfer(input string tag, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input int waits, input bit stuck);
        bit          err;
        int          expAcc;
        int          n;
        logic [DW:0] r;
        err    = stuck || (waits >= TIMEOUT);
        expAcc = err ? TIMEOUT : waits + 1;
        slvWaits = waits;
        slvStuck = stuck;
        @(negedge pclk);
        drive(wr, a, d, s);
        chk({tag, "_ready_idle"}, bus.req_ready, 1);
        model(wr, a, d, s, err, r);
        exp_q.push_back(r);
        @(negedge pclk);
        bus.req_valid = 1'b0;
        chk({tag, "_setup_psel_pen"}, {bus.psel, bus.penable}, 2'b10);
        chk({tag, "_setup_addr"}, bus.pADDr, a);
        chk({tag, "_setup_write"}, bus.pWRITE, wr);
        chk({tag, "_setup_strb"}, bus.pSTRB, wr ? s : 4'h0);
        if (wr) chk({tag, "_setup_wdata"}, bus.pWDATA, d);
        chk({tag, "_setup_ready"}, bus.req_ready, 0);
        n = 0;
        while (n < TIMEOUT + 4) begin
            @(negedge pclk);
            if (bus.rsp_valid) break;
            n++;
            chk({tag, "_access_psel_pen"}, {bus.psel, bus.penable}, 2'b11);
            chk({tag, "_access_ready"}, bus.req_ready, (n == expAcc));
        end
        chk({tag, "_access_len"}, n, expAcc);
        chk({tag, "_rsp_seen"}, bus.rsp_valid, 1);
        chk({tag, "_idle_psel_pen"}, {bus.psel, bus.penable}, 2'b00);
        @(negedge pclk);
        chk({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
        slvStuck = 1'b0;
    endtask

    initial begin : main
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW:0]   r;
        logic [1:0]    pe;
        int            rspStart;

        for (int i = 0; i < 256; i++) begin
            refMem[i] = '0;
            slvMem[i] = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;

        // Reset state
        #1 prst = 1'b1;
        #11;
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_paddr", bus.pADDr, 0);
        chk("rst_pwdata", bus.pWDATA, 0);
        chk("rst_pstrb", bus.pSTRB, 0);
        chk("rst_pwrite", bus.pWRITE, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_state", dbgState, 0);
        @(negedge pclk);
        prst = 1'b0;
        #1 chk("post_rst_req_ready", bus.req_ready, 1);

        // Single write answered one ACCESS cycle late, then read back
        do_xfer("wr1", 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0);
        do_xfer("rd1", 1'b0, 8'h10, 32'h0, 4'hF, 0, 1'b0);

        // Partial strobe over an all-ones word
        do_xfer("wr_ff", 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
        do_xfer("wr_part", 1'b1, 8'h20, 32'h11223344, 4'b0101, 2, 1'b0);
        do_xfer("rd_part", 1'b0, 8'h20, 32'h0, 4'hF, 0, 1'b0);

        // Back-to-back with req_valid held: write 0x01, write 0x02, read 0x01
        slvWaits = 0;
        d0 = $urandom;
        d1 = $urandom;
        rspStart = rspCount;
        @(negedge pclk);
        drive(1'b1, 8'h01, d0, 4'hF);
        model(1'b1, 8'h01, d0, 4'hF, 1'b0, r);
        exp_q.push_back(r);
        for (int i = 1; i <= 7; i++) begin
            @(negedge pclk);
            pe = (i == 7) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b11);
            chk("b2b_psel_pen", {bus.psel, bus.penable}, pe);
            chk("b2b_req_ready", bus.req_ready, (i % 2 == 0) || (i == 7));
            if (i < 7) chk("b2b_no_idle", (dbgState == 2'b00), 0);
            if (i == 2) begin
                drive(1'b1, 8'h02, d1, 4'hF);
                model(1'b1, 8'h02, d1, 4'hF, 1'b0, r);
                exp_q.push_back(r);
            end else if (i == 4) begin
                drive(1'b0, 8'h01, 32'h0, 4'hF);
                model(1'b0, 8'h01, 32'h0, 4'hF, 1'b0, r);
                exp_q.push_back(r);
            end else if (i == 6) begin
                bus.req_valid = 1'b0;
            end
        end
        @(negedge pclk);
        @(negedge pclk);
        chk("b2b_rsp_count", rspCount - rspStart, 3);

        // Timeout with pREADY tied low, then a normal transfer
        do_xfer("tmo", 1'b0, 8'h30, 32'h0, 4'hF, 0, 1'b1);
        do_xfer("post_tmo", 1'b0, 8'h10, 32'h0, 4'hF, 0, 1'b0);

        // pREADY rising on the last allowed ACCESS cycle
        do_xfer("race_rd", 1'b0, 8'h20, 32'h0, 4'hF, TIMEOUT - 1, 1'b0);
        do_xfer("race_wr", 1'b1, 8'h40, 32'hCAFEF00D, 4'hF, TIMEOUT - 1, 1'b0);
        do_xfer("race_chk", 1'b0, 8'h40, 32'h0, 4'hF, 0, 1'b0);

        // Asynchronous reset in the middle of ACCESS
        slvStuck = 1'b1;
        @(negedge pclk);
        drive(1'b0, 8'h30, 32'h0, 4'hF);
        @(negedge pclk);
        bus.req_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        #2 prst = 1'b1;
        #1;
        chk("mid_rst_psel", bus.psel, 0);
        chk("mid_rst_penable", bus.penable, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_state", dbgState, 0);
        @(negedge pclk);
        prst = 1'b0;
        slvStuck = 1'b0;
        #1 chk("mid_rst_req_ready", bus.req_ready, 1);
        repeat (4) @(negedge pclk);
        do_xfer("after_rst", 1'b0, 8'h10, 32'h0, 4'hF, 1, 1'b0);

        // Randomized traffic against the memory model
        for (int k = 0; k < 40; k++) begin
            bit            wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [SW-1:0] s;
            int            w;
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 15));
            d  = $urandom;
            s  = SW'($urandom_range(0, 15));
            w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                              : $urandom_range(0, 3);
            do_xfer("rand", wr, a, d, s, w, 1'b0);
        end

        @(negedge pclk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
